// File: rtl/edit_mode_controller.sv
// Edit-mode controller for a clock setting UI: two debounced keys drive a
// NORMAL/HOUR/MIN/SEC field selector with increment and mode-change pulses.
// Optional macro EDIT_TIMEOUT_EN adds an idle auto-exit from edit mode.
module edit_mode_controller #(
    parameter int DEBOUNCE_CYC = 500_000,
    parameter int LONG_CYC     = 50_000_000,
    parameter int TIMEOUT_CYC  = 500_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_edit,
    input  logic       key_up,
    output logic [1:0] field_sel,
    output logic       edit_mode,
    output logic       inc_pulse,
    output logic       mode_pulse
);

    // The post-reset arming window must outlast the two synchronizer cycles
    // that still carry reset values, hence the lower bound on DEBOUNCE_CYC.
    if (DEBOUNCE_CYC < 3 || LONG_CYC < 2 || TIMEOUT_CYC < 2) begin : g_bad_params
        $error("edit_mode_controller: parameter out of range");
    end

    localparam int DW = $clog2(DEBOUNCE_CYC);
    localparam int LW = $clog2(LONG_CYC + 1);
    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYC - 1);
    localparam logic [LW-1:0] LONG_LAST = LW'(LONG_CYC - 1);
    localparam logic [LW-1:0] LONG_MAX  = LW'(LONG_CYC);

    typedef enum logic [1:0] {
        S_NORMAL = 2'b00,
        S_HOUR   = 2'b01,
        S_MIN    = 2'b10,
        S_SEC    = 2'b11
    } state_t;

    // Index 0 is key_edit, index 1 is key_up.
    logic [1:0]    key_raw;
    logic [1:0]    sync1;
    logic [1:0]    sync2;
    logic [1:0]    deb;
    logic [1:0]    deb_q;
    logic [1:0]    armed;
    logic [DW-1:0] dcnt [2];
    logic [DW-1:0] qcnt [2];

    logic [LW-1:0] hold_cnt;
    logic          edit_rel;
    logic          up_press;
    logic          long_evt;
    logic          short_evt;
    logic          timeout_hit;

    state_t        state;

    assign key_raw = {key_up, key_edit};

    // Synchronize, debounce and arm both keys. A key only becomes armed after
    // its debounced level has been high (released) for a full debounce window,
    // so a key held through reset generates nothing until released and re-pressed.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1 <= 2'b11;
            sync2 <= 2'b11;
            deb   <= 2'b11;
            deb_q <= 2'b11;
            armed <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                dcnt[i] <= '0;
                qcnt[i] <= '0;
            end
        end else begin
            sync1 <= key_raw;
            sync2 <= sync1;
            deb_q <= deb;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == deb[i]) begin
                    dcnt[i] <= '0;
                end else if (dcnt[i] == DB_LAST) begin
                    deb[i]  <= sync2[i];
                    dcnt[i] <= '0;
                end else begin
                    dcnt[i] <= dcnt[i] + 1'b1;
                end

                if (!armed[i]) begin
                    if (!sync2[i] || !deb[i]) begin
                        qcnt[i] <= '0;
                    end else if (qcnt[i] == DB_LAST) begin
                        armed[i] <= 1'b1;
                        qcnt[i]  <= '0;
                    end else begin
                        qcnt[i] <= qcnt[i] + 1'b1;
                    end
                end
            end
        end
    end

    assign edit_rel = armed[0] & ~deb_q[0] & deb[0];
    assign up_press = armed[1] & deb_q[1] & ~deb[1];

    // Hold duration of key_edit; saturates so the long event cannot repeat.
    always_ff @(posedge clk) begin
        if (!reset) begin
            hold_cnt <= '0;
        end else if (deb[0] || !armed[0]) begin
            hold_cnt <= '0;
        end else if (hold_cnt != LONG_MAX) begin
            hold_cnt <= hold_cnt + 1'b1;
        end
    end

    // hold_cnt is still at its held value in the release-edge cycle, so a
    // saturated counter there means the long event already fired.
    assign long_evt  = armed[0] & ~deb[0] & (hold_cnt == LONG_LAST);
    assign short_evt = edit_rel & (hold_cnt != LONG_MAX);

`ifdef EDIT_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);

    logic          edit_press;
    logic [TW-1:0] idle_cnt;

    assign edit_press = armed[0] & deb_q[0] & ~deb[0];

    // Idle time spent in an edit state; any press edge restarts it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            idle_cnt <= '0;
        end else if (state == S_NORMAL || edit_press || up_press) begin
            idle_cnt <= '0;
        end else if (!timeout_hit) begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end

    assign timeout_hit = (state != S_NORMAL) && (idle_cnt == TO_LAST)
                         && !edit_press && !up_press;
`else
    assign timeout_hit = 1'b0;
`endif

    // Mode FSM. Priority: long event, timeout, short event, then key_up, so
    // an edit-key event or an exit always swallows a coincident increment.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= S_NORMAL;
            edit_mode  <= 1'b0;
            inc_pulse  <= 1'b0;
            mode_pulse <= 1'b0;
        end else begin
            inc_pulse  <= 1'b0;
            mode_pulse <= 1'b0;
            if (long_evt) begin
                mode_pulse <= 1'b1;
                if (state == S_NORMAL) begin
                    state     <= S_HOUR;
                    edit_mode <= 1'b1;
                end else begin
                    state     <= S_NORMAL;
                    edit_mode <= 1'b0;
                end
            end else if (timeout_hit) begin
                mode_pulse <= 1'b1;
                state      <= S_NORMAL;
                edit_mode  <= 1'b0;
            end else if (state != S_NORMAL) begin
                if (short_evt) begin
                    case (state)
                        S_HOUR:  state <= S_MIN;
                        S_MIN:   state <= S_SEC;
                        default: state <= S_HOUR;
                    endcase
                end else if (up_press) begin
                    inc_pulse <= 1'b1;
                end
            end
        end
    end

    assign field_sel = state;

endmodule

// File: tb/tb_edit_mode_controller.sv
// Directed bench for edit_mode_controller with short debounce/hold timing.
// Table rows hold key levels for a number of cycles and check the outcome.
// Hand sequences cover coincident events, reset mid-hold and idle timeout.
module tb_edit_mode_controller;

    localparam int DEB = 4;
    localparam int LNG = 20;
    localparam int TO  = 100;

    logic       clk = 1'b0;
    logic       reset;
    logic       key_edit;
    logic       key_up;
    logic [1:0] field_sel;
    logic       edit_mode;
    logic       inc_pulse;
    logic       mode_pulse;

    int checks = 0;
    int errors = 0;
    int inc_total = 0;
    int mode_total = 0;

    always #5 clk = ~clk;

    edit_mode_controller #(
        .DEBOUNCE_CYC(DEB),
        .LONG_CYC    (LNG),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .key_edit  (key_edit),
        .key_up    (key_up),
        .field_sel (field_sel),
        .edit_mode (edit_mode),
        .inc_pulse (inc_pulse),
        .mode_pulse(mode_pulse)
    );

    // Pulse-high cycles, sampled away from the active edge.
    always @(negedge clk) begin
        if (inc_pulse)  inc_total  <= inc_total + 1;
        if (mode_pulse) mode_total <= mode_total + 1;
    end

    typedef struct {
        logic       ke;
        logic       ku;
        int         cyc;
        logic [1:0] fs;
        int         inc;
        int         mode;
    } vec_t;

    localparam int NV = 27;
    vec_t vecs [NV];

    task automatic chk(input string nm, input int idx, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %0d expected %0d", nm, idx, act, exp);
        end
    endtask

    task automatic run(input logic ke, input logic ku, input int n,
                       output int dinc, output int dmode);
        int i0;
        int m0;
        key_edit = ke;
        key_up   = ku;
        i0 = inc_total;
        m0 = mode_total;
        repeat (n) @(posedge clk);
        #1;
        dinc  = inc_total - i0;
        dmode = mode_total - m0;
    endtask

    task automatic check_state(input string nm, input int idx, input logic [1:0] fs,
                               input int dinc, input int exp_inc,
                               input int dmode, input int exp_mode);
        chk({nm, ".field_sel"}, idx, int'(field_sel), int'(fs));
        chk({nm, ".edit_mode"}, idx, int'(edit_mode), int'(fs != 2'b00));
        chk({nm, ".inc_pulses"}, idx, dinc, exp_inc);
        chk({nm, ".mode_pulses"}, idx, dmode, exp_mode);
    endtask

    initial begin
        int a_inc, a_mode, b_inc, b_mode;

        // ke, ku, cycles, expected field_sel, inc pulses, mode pulses
        vecs[0]  = '{1'b1, 1'b1, 10, 2'b00, 0, 0};  // idle after reset
        vecs[1]  = '{1'b0, 1'b1,  2, 2'b00, 0, 0};  // 2-cycle glitch
        vecs[2]  = '{1'b1, 1'b1, 20, 2'b00, 0, 0};
        vecs[3]  = '{1'b1, 1'b0, 10, 2'b00, 0, 0};  // key_up in NORMAL x3
        vecs[4]  = '{1'b1, 1'b1, 10, 2'b00, 0, 0};
        vecs[5]  = '{1'b1, 1'b0, 10, 2'b00, 0, 0};
        vecs[6]  = '{1'b1, 1'b1, 10, 2'b00, 0, 0};
        vecs[7]  = '{1'b1, 1'b0, 10, 2'b00, 0, 0};
        vecs[8]  = '{1'b1, 1'b1, 10, 2'b00, 0, 0};
        vecs[9]  = '{1'b0, 1'b1, 40, 2'b01, 0, 1};  // long press enters HOUR
        vecs[10] = '{1'b1, 1'b1, 10, 2'b01, 0, 0};  // release: no short event
        vecs[11] = '{1'b0, 1'b1, 10, 2'b01, 0, 0};  // short press
        vecs[12] = '{1'b1, 1'b1, 10, 2'b10, 0, 0};  // -> MIN
        vecs[13] = '{1'b0, 1'b1, 10, 2'b10, 0, 0};
        vecs[14] = '{1'b1, 1'b1, 10, 2'b11, 0, 0};  // -> SEC
        vecs[15] = '{1'b0, 1'b1, 10, 2'b11, 0, 0};
        vecs[16] = '{1'b1, 1'b1, 10, 2'b01, 0, 0};  // wrap -> HOUR
        vecs[17] = '{1'b0, 1'b1, 10, 2'b01, 0, 0};
        vecs[18] = '{1'b1, 1'b1, 10, 2'b10, 0, 0};  // -> MIN
        vecs[19] = '{1'b1, 1'b0, 10, 2'b10, 1, 0};  // key_up in MIN x3
        vecs[20] = '{1'b1, 1'b1, 10, 2'b10, 0, 0};
        vecs[21] = '{1'b1, 1'b0, 10, 2'b10, 1, 0};
        vecs[22] = '{1'b1, 1'b1, 10, 2'b10, 0, 0};
        vecs[23] = '{1'b1, 1'b0, 10, 2'b10, 1, 0};
        vecs[24] = '{1'b1, 1'b1, 10, 2'b10, 0, 0};
        vecs[25] = '{1'b0, 1'b1, 40, 2'b00, 0, 1};  // long press exits
        vecs[26] = '{1'b1, 1'b1, 10, 2'b00, 0, 0};

        reset    = 1'b0;
        key_edit = 1'b1;
        key_up   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset.field_sel",  0, int'(field_sel),  0);
        chk("reset.edit_mode",  0, int'(edit_mode),  0);
        chk("reset.inc_pulse",  0, int'(inc_pulse),  0);
        chk("reset.mode_pulse", 0, int'(mode_pulse), 0);
        reset = 1'b1;

        for (int i = 0; i < NV; i++) begin
            run(vecs[i].ke, vecs[i].ku, vecs[i].cyc, a_inc, a_mode);
            check_state("vec", i, vecs[i].fs, a_inc, vecs[i].inc, a_mode, vecs[i].mode);
        end

        // Reach EDIT_SEC, then align key_up's press edge with the long event.
        run(1'b0, 1'b1, 40, a_inc, a_mode);
        check_state("sec_entry", 0, 2'b01, a_inc, 0, a_mode, 1);
        run(1'b1, 1'b1, 10, a_inc, a_mode);
        run(1'b0, 1'b1, 10, a_inc, a_mode);
        run(1'b1, 1'b1, 10, a_inc, a_mode);
        run(1'b0, 1'b1, 10, a_inc, a_mode);
        run(1'b1, 1'b1, 10, a_inc, a_mode);
        check_state("sec_reach", 0, 2'b11, a_inc, 0, a_mode, 0);
        run(1'b0, 1'b1, LNG - 1, a_inc, a_mode);
        run(1'b0, 1'b0, 30, b_inc, b_mode);
        check_state("coincide", 0, 2'b00, a_inc + b_inc, 0, a_mode + b_mode, 1);
        run(1'b1, 1'b1, 20, a_inc, a_mode);
        check_state("coincide_rel", 0, 2'b00, a_inc, 0, a_mode, 0);

        // Reset in the middle of a hold while in edit mode, key kept down.
        run(1'b0, 1'b1, 40, a_inc, a_mode);
        check_state("rst_entry", 0, 2'b01, a_inc, 0, a_mode, 1);
        run(1'b1, 1'b1, 10, a_inc, a_mode);
        run(1'b0, 1'b1, 10, a_inc, a_mode);
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mid.field_sel", 0, int'(field_sel), 0);
        chk("rst_mid.edit_mode", 0, int'(edit_mode), 0);
        reset = 1'b1;
        run(1'b0, 1'b1, 40, a_inc, a_mode);
        check_state("rst_held", 0, 2'b00, a_inc, 0, a_mode, 0);
        run(1'b1, 1'b1, 20, a_inc, a_mode);
        check_state("rst_rel", 0, 2'b00, a_inc, 0, a_mode, 0);
        run(1'b0, 1'b1, 40, a_inc, a_mode);
        check_state("rst_repress", 0, 2'b01, a_inc, 0, a_mode, 1);
        run(1'b1, 1'b1, 10, a_inc, a_mode);
        check_state("rst_repress_rel", 0, 2'b01, a_inc, 0, a_mode, 0);

`ifdef EDIT_TIMEOUT_EN
        run(1'b1, 1'b1, 60, a_inc, a_mode);
        check_state("idle_before_to", 0, 2'b01, a_inc, 0, a_mode, 0);
        run(1'b1, 1'b1, 30, a_inc, a_mode);
        check_state("idle_timeout", 0, 2'b00, a_inc, 0, a_mode, 1);
`else
        run(1'b1, 1'b1, 1000, a_inc, a_mode);
        check_state("idle_no_timeout", 0, 2'b01, a_inc, 0, a_mode, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
